// File: rtl/clk_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_pattern_gen
//  Description : Programmable clock-pattern generator. Produces clk_out with
//                independently programmable high and low durations counted in
//                clk cycles. New settings arrive over a valid/ready handshake
//                into a shadow slot and are applied only at a period
//                boundary, so clk_out never shows a runt pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W       width of the high/low duration fields
//    PCNT_W      width of the completed-period counter
//  Ports
//    clk         system clock, rising edge
//    rst         synchronous active-high reset
//    en          run request; a period in progress always completes
//    cfg_valid   new configuration offered
//    cfg_ready   shadow slot free (accept = cfg_valid && cfg_ready)
//    cfg_high    high duration in cycles (0 treated as 1)
//    cfg_low     low duration in cycles (0 treated as 1)
//    clk_out     generated clock, 1 exactly while in HIGH
//    period_done one-cycle pulse during the last LOW cycle of each period
//    busy        FSM not in IDLE
//    period_cnt  completed periods since reset (wraps silently)
//  Build option
//    CLK_GEN_PERIOD_CNT_EN  when defined, the period counter is built;
//                           otherwise period_cnt is tied to 0.
// ============================================================================
module clk_pattern_gen #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    output logic              clk_out,
    output logic              period_done,
    output logic              busy,
    output logic [PCNT_W-1:0] period_cnt
);

    localparam logic [CNT_W-1:0] c_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_act_high;
    logic [CNT_W-1:0] r_act_low;
    logic [CNT_W-1:0] r_sh_high;
    logic [CNT_W-1:0] r_sh_low;
    logic             r_pend;
    logic             r_period_done;
    logic             w_apply;
    logic             w_period_end;
    logic             w_accept;
    logic [CNT_W-1:0] w_start_high;

    assign w_accept = cfg_valid && !r_pend;

    // High duration of a period starting this edge: the shadow value wins
    // when a config is pending, since it is applied on this same edge.
    assign w_start_high = r_pend ? r_sh_high : r_act_high;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_apply      = 1'b0;
        w_period_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next_state = S_HIGH;
                    w_apply      = r_pend;
                    w_next_cnt   = w_start_high - c_ONE;
                end
            end
            S_HIGH: begin
                if (r_cnt == c_ZERO) begin
                    w_next_state = S_LOW;
                    w_next_cnt   = r_act_low - c_ONE;
                end else begin
                    w_next_cnt   = r_cnt - c_ONE;
                end
            end
            S_LOW: begin
                if (r_cnt == c_ZERO) begin
                    w_period_end = 1'b1;
                    if (en) begin
                        w_next_state = S_HIGH;
                        w_apply      = r_pend;
                        w_next_cnt   = w_start_high - c_ONE;
                    end else begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = c_ZERO;
                    end
                end else begin
                    w_next_cnt   = r_cnt - c_ONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = c_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= c_ZERO;
            r_act_high    <= c_ONE;
            r_act_low     <= c_ONE;
            r_sh_high     <= c_ONE;
            r_sh_low      <= c_ONE;
            r_pend        <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            // Registered pulse: high while the upcoming cycle is the last LOW.
            r_period_done <= (w_next_state == S_LOW) && (w_next_cnt == c_ZERO);

            // Apply and accept are mutually exclusive: apply needs pend=1,
            // accept needs pend=0.
            if (w_apply) begin
                r_act_high <= r_sh_high;
                r_act_low  <= r_sh_low;
                r_pend     <= 1'b0;
            end else if (w_accept) begin
                r_sh_high  <= (cfg_high == c_ZERO) ? c_ONE : cfg_high;
                r_sh_low   <= (cfg_low  == c_ZERO) ? c_ONE : cfg_low;
                r_pend     <= 1'b1;
            end
        end
    end

`ifdef CLK_GEN_PERIOD_CNT_EN
    logic [PCNT_W-1:0] r_period_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_period_end) begin
            r_period_cnt <= r_period_cnt + {{(PCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign period_cnt = r_period_cnt;
`else
    logic w_unused_period_end;
    assign w_unused_period_end = w_period_end;
    assign period_cnt          = '0;
`endif

    assign clk_out     = (r_state == S_HIGH);
    assign busy        = (r_state != S_IDLE);
    assign cfg_ready   = !r_pend;
    assign period_done = r_period_done;

endmodule
`default_nettype wire

// File: tb/tb_clk_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_pattern_gen
//  Description : Directed self-checking bench for clk_pattern_gen. Inputs
//                change on the falling edge; outputs are sampled on the
//                falling edge after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_pattern_gen;

    localparam int CNT_W  = 16;
    localparam int PCNT_W = 32;

    logic              clk;
    logic              rst;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_low;
    logic              clk_out;
    logic              period_done;
    logic              busy;
    logic [PCNT_W-1:0] period_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_pcnt = 0;

    clk_pattern_gen #(
        .CNT_W  (CNT_W),
        .PCNT_W (PCNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .clk_out     (clk_out),
        .period_done (period_done),
        .busy        (busy),
        .period_cnt  (period_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock, then compare every output against the hand-given values.
    task automatic expect_cycle(input string tag, input logic e_clk,
                                input logic e_pd, input logic e_busy,
                                input logic e_rdy);
        logic [31:0] e_pcnt;
        step();
`ifdef CLK_GEN_PERIOD_CNT_EN
        e_pcnt = 32'(exp_pcnt);
`else
        e_pcnt = 32'd0;
`endif
        check_val({tag, ".clk_out"},     32'(clk_out),     32'(e_clk));
        check_val({tag, ".period_done"}, 32'(period_done), 32'(e_pd));
        check_val({tag, ".busy"},        32'(busy),        32'(e_busy));
        check_val({tag, ".cfg_ready"},   32'(cfg_ready),   32'(e_rdy));
        check_val({tag, ".period_cnt"},  32'(period_cnt),  e_pcnt);
        if (e_pd) exp_pcnt++;
    endtask

    // One full period of hi high cycles then lo low cycles, en held high.
    task automatic expect_period(input string tag, input int hi, input int lo,
                                 input logic e_rdy);
        for (int i = 0; i < hi; i++) expect_cycle(tag, 1'b1, 1'b0, 1'b1, e_rdy);
        for (int i = 0; i < lo; i++) expect_cycle(tag, 1'b0, (i == lo - 1), 1'b1, e_rdy);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_high  = '0;
        cfg_low   = '0;
        step();
        step();

        // Reset state
        rst = 1'b0;
        exp_pcnt = 0;
        expect_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b1);

        // Defaults 1/1
        en = 1'b1;
        expect_period("dflt", 1, 1, 1'b1);
        expect_period("dflt", 1, 1, 1'b1);
        expect_period("dflt", 1, 1, 1'b1);
        en = 1'b0;
        expect_cycle("dflt_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Accept 3/2 while idle, then run
        cfg_valid = 1'b1; cfg_high = 16'd3; cfg_low = 16'd2;
        expect_cycle("idle_acc", 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        en = 1'b1;
        expect_period("p32", 3, 2, 1'b1);
        expect_period("p32", 3, 2, 1'b1);

        // Offer 1/4 mid-HIGH: current period stays 3/2
        expect_cycle("mid_h1", 1'b1, 1'b0, 1'b1, 1'b1);
        cfg_valid = 1'b1; cfg_high = 16'd1; cfg_low = 16'd4;
        expect_cycle("mid_h2", 1'b1, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        expect_cycle("mid_h3", 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cycle("mid_l1", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("mid_l2", 1'b0, 1'b1, 1'b1, 1'b0);
        expect_period("p14", 1, 4, 1'b1);
        expect_period("p14", 1, 4, 1'b1);

        // Offer 0/0 at a boundary; then 5/5 while pending (must be ignored)
        cfg_valid = 1'b1; cfg_high = 16'd0; cfg_low = 16'd0;
        expect_cycle("clamp_h", 1'b1, 1'b0, 1'b1, 1'b0);
        cfg_high = 16'd5; cfg_low = 16'd5;
        expect_cycle("clamp_l1", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("clamp_l2", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("clamp_l3", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("clamp_l4", 1'b0, 1'b1, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        expect_period("p11", 1, 1, 1'b1);
        expect_period("p11", 1, 1, 1'b1);

        // Load 4/4, then drop en during HIGH
        cfg_valid = 1'b1; cfg_high = 16'd4; cfg_low = 16'd4;
        expect_cycle("ld44_h", 1'b1, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        expect_cycle("ld44_l", 1'b0, 1'b1, 1'b1, 1'b0);
        expect_cycle("drop_h1", 1'b1, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) expect_cycle("drop_h", 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) expect_cycle("drop_l", 1'b0, 1'b0, 1'b1, 1'b1);
        expect_cycle("drop_pd", 1'b0, 1'b1, 1'b1, 1'b1);
        expect_cycle("drop_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle("drop_idle2", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-LOW with a pending 2/3
        en = 1'b1;
        cfg_valid = 1'b1; cfg_high = 16'd2; cfg_low = 16'd3;
        expect_cycle("rst_h1", 1'b1, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) expect_cycle("rst_h", 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cycle("rst_l1", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle("rst_l2", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        exp_pcnt = 0;
        expect_cycle("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        expect_period("post_rst", 1, 1, 1'b1);
        expect_period("post_rst", 1, 1, 1'b1);
        en = 1'b0;
        expect_cycle("end_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
